// File: rtl/ahb_sram_slave.sv
// ahb_sram_slave: AHB-Lite slave in front of a byte-addressed internal SRAM.
//
// Accepts byte, halfword and word transfers and adds an optional fixed number
// of wait states to each OKAY data phase. It responds with a two-cycle ERROR
// to out-of-range, oversize or misaligned transfers. A read whose address
// phase lines up with the completing data phase of a write sees the new bytes.
//
// Ports:
//   HCLK      in   bus clock, rising edge
//   HRST      in   synchronous active-high reset
//   HSEL_i    in   slave select
//   HADDR_i   in   [31:0] byte address
//   HTRANS_i  in   [1:0] IDLE/BUSY/NONSEQ/SEQ
//   HWRITE_i  in   1 = write
//   HSIZE_i   in   [2:0] 0 byte, 1 halfword, 2 word
//   HBURST_i  in   [2:0] burst type (ignored)
//   HWDATA_i  in   [31:0] write data, right-justified
//   HREADY_i  in   bus-level HREADY
//   HRDATA_o  out  [31:0] read data, right-justified
//   HREADY_o  out  transfer done
//   HRESP_o   out  0 OKAY, 1 ERROR
module ahb_sram_slave #(
    parameter int unsigned MEM_BYTES   = 512,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        HCLK,
    input  logic        HRST,
    input  logic        HSEL_i,
    input  logic [31:0] HADDR_i,
    input  logic [1:0]  HTRANS_i,
    input  logic        HWRITE_i,
    input  logic [2:0]  HSIZE_i,
    input  logic [2:0]  HBURST_i,
    input  logic [31:0] HWDATA_i,
    input  logic        HREADY_i,
    output logic [31:0] HRDATA_o,
    output logic        HREADY_o,
    output logic        HRESP_o
);

    localparam int unsigned AW = $clog2(MEM_BYTES);
    // WAIT lasts WAIT_STATES cycles: load N-1, leave when the counter hits 0.
    localparam logic [2:0] WaitInit = (WAIT_STATES > 0) ? 3'(WAIT_STATES - 1) : 3'd0;

    typedef enum logic [2:0] {StIdle, StWait, StOkay, StErr1, StErr2} state_e;

    state_e          state_q;
    logic [AW-1:0]   addr_q;
    logic            write_q;
    logic [2:0]      size_q;
    logic [2:0]      wait_cnt_q;
    logic [7:0]      mem_q [MEM_BYTES];

    logic            start;
    logic            req_err;
    logic            wr_now;
    logic [AW-1:0]   rd_base;
    logic [2:0]      rd_size;
    logic [AW-1:0]   rd_idx;
    logic [7:0]      rd_byte;
    logic [31:0]     wr_off;
    logic [31:0]     rd_data;

    logic unused_inputs;
    assign unused_inputs = ^{HBURST_i, HTRANS_i[0]};

    function automatic logic [2:0] size_bytes(input logic [2:0] size);
        case (size)
            3'd0:    return 3'd1;
            3'd1:    return 3'd2;
            default: return 3'd4;
        endcase
    endfunction

    // Only NONSEQ/SEQ start a transfer; the FSM decides whether it may be taken.
    assign start   = HSEL_i && HREADY_i && HTRANS_i[1];
    assign req_err = (HADDR_i >= MEM_BYTES) || (HSIZE_i > 3'd2) ||
                     ((HSIZE_i == 3'd1) && HADDR_i[0]) ||
                     ((HSIZE_i == 3'd2) && (HADDR_i[1:0] != 2'b00));

    // Write data phase completes at the end of an OKAY cycle.
    assign wr_now  = (state_q == StOkay) && write_q;

    // Read data is captured on entry to OKAY: straight from the address phase
    // when there are no wait states, else from the registered address.
    assign rd_base = (state_q == StWait) ? addr_q : HADDR_i[AW-1:0];
    assign rd_size = (state_q == StWait) ? size_q : HSIZE_i;

    always_comb begin
        rd_data = '0;
        rd_idx  = '0;
        rd_byte = '0;
        wr_off  = '0;
        for (int k = 0; k < 4; k++) begin
            rd_idx  = rd_base + AW'(k);
            rd_byte = mem_q[rd_idx];
            // Forward bytes being written at this same edge.
            wr_off  = 32'(rd_idx) - 32'(addr_q);
            if (wr_now && (wr_off < 32'(size_bytes(size_q)))) begin
                rd_byte = HWDATA_i[{wr_off[1:0], 3'b000} +: 8];
            end
            if (3'(k) < size_bytes(rd_size)) begin
                rd_data[8*k +: 8] = rd_byte;
            end
        end
    end

    // Array has no reset so contents survive HRST.
    always_ff @(posedge HCLK) begin
        if (!HRST && wr_now) begin
            for (int k = 0; k < 4; k++) begin
                if (3'(k) < size_bytes(size_q)) begin
                    mem_q[addr_q + AW'(k)] <= HWDATA_i[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRST) begin
            state_q    <= StIdle;
            addr_q     <= '0;
            write_q    <= 1'b0;
            size_q     <= 3'd0;
            wait_cnt_q <= 3'd0;
            HREADY_o   <= 1'b1;
            HRESP_o    <= 1'b0;
            HRDATA_o   <= '0;
        end else begin
            case (state_q)
                StIdle, StOkay, StErr2: begin
                    if (start) begin
                        addr_q  <= HADDR_i[AW-1:0];
                        write_q <= HWRITE_i;
                        size_q  <= HSIZE_i;
                        if (req_err) begin
                            state_q  <= StErr1;
                            HREADY_o <= 1'b0;
                            HRESP_o  <= 1'b1;
                            HRDATA_o <= '0;
                        end else if (WAIT_STATES > 0) begin
                            state_q    <= StWait;
                            wait_cnt_q <= WaitInit;
                            HREADY_o   <= 1'b0;
                            HRESP_o    <= 1'b0;
                            HRDATA_o   <= '0;
                        end else begin
                            state_q  <= StOkay;
                            HREADY_o <= 1'b1;
                            HRESP_o  <= 1'b0;
                            HRDATA_o <= HWRITE_i ? 32'h0 : rd_data;
                        end
                    end else begin
                        state_q  <= StIdle;
                        HREADY_o <= 1'b1;
                        HRESP_o  <= 1'b0;
                        HRDATA_o <= '0;
                    end
                end
                StWait: begin
                    if (wait_cnt_q == 3'd0) begin
                        state_q  <= StOkay;
                        HREADY_o <= 1'b1;
                        HRESP_o  <= 1'b0;
                        HRDATA_o <= write_q ? 32'h0 : rd_data;
                    end else begin
                        wait_cnt_q <= wait_cnt_q - 3'd1;
                    end
                end
                StErr1: begin
                    state_q  <= StErr2;
                    HREADY_o <= 1'b1;
                    HRESP_o  <= 1'b1;
                    HRDATA_o <= '0;
                end
                default: begin
                    state_q  <= StIdle;
                    HREADY_o <= 1'b1;
                    HRESP_o  <= 1'b0;
                    HRDATA_o <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: instance 0 with no wait states, instance 1 with
// two. A pipelined master drives transfer lists; a byte-array memory model
// predicts every data-phase response.
module tb_ahb_sram_slave;

    localparam int unsigned MEM = 512;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        hrst    [2];
    logic        hsel    [2];
    logic [31:0] haddr   [2];
    logic [1:0]  htrans  [2];
    logic        hwrite  [2];
    logic [2:0]  hsize   [2];
    logic [2:0]  hburst  [2];
    logic [31:0] hwdata  [2];
    logic        hready_i[2];
    logic [31:0] hrdata  [2];
    logic        hready_o[2];
    logic        hresp   [2];

    assign hready_i[0] = hready_o[0];
    assign hready_i[1] = hready_o[1];

    ahb_sram_slave #(.MEM_BYTES(MEM), .WAIT_STATES(0)) dut0 (
        .HCLK(clk), .HRST(hrst[0]), .HSEL_i(hsel[0]), .HADDR_i(haddr[0]),
        .HTRANS_i(htrans[0]), .HWRITE_i(hwrite[0]), .HSIZE_i(hsize[0]),
        .HBURST_i(hburst[0]), .HWDATA_i(hwdata[0]), .HREADY_i(hready_i[0]),
        .HRDATA_o(hrdata[0]), .HREADY_o(hready_o[0]), .HRESP_o(hresp[0])
    );

    ahb_sram_slave #(.MEM_BYTES(MEM), .WAIT_STATES(2)) dut1 (
        .HCLK(clk), .HRST(hrst[1]), .HSEL_i(hsel[1]), .HADDR_i(haddr[1]),
        .HTRANS_i(htrans[1]), .HWRITE_i(hwrite[1]), .HSIZE_i(hsize[1]),
        .HBURST_i(hburst[1]), .HWDATA_i(hwdata[1]), .HREADY_i(hready_i[1]),
        .HRDATA_o(hrdata[1]), .HREADY_o(hready_o[1]), .HRESP_o(hresp[1])
    );

    typedef struct {
        logic        sel;
        logic [1:0]  trans;
        logic        write;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } item_t;

    item_t       seq[$];
    logic [7:0]  mm [2][MEM];
    bit          mv [2][MEM];
    int          wst [2] = '{0, 2};
    int          checks = 0;
    int          failures = 0;
    logic [31:0] last_rdata;

    function automatic bit is_err(input item_t it);
        return (it.addr >= MEM) || (it.size > 3'd2) ||
               ((it.size == 3'd1) && it.addr[0]) ||
               ((it.size == 3'd2) && (it.addr[1:0] != 2'b00));
    endfunction

    function automatic int nbytes(input logic [2:0] s);
        return (s == 3'd0) ? 1 : (s == 3'd1) ? 2 : 4;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic add(input logic sel, input logic [1:0] trans, input logic write,
                       input logic [2:0] size, input logic [31:0] addr,
                       input logic [31:0] wdata);
        item_t it;
        it.sel = sel; it.trans = trans; it.write = write;
        it.size = size; it.addr = addr; it.wdata = wdata;
        seq.push_back(it);
    endtask

    task automatic drive(input int d, input item_t ap, input logic [31:0] wd);
        hsel[d]   = ap.sel;
        htrans[d] = ap.trans;
        hwrite[d] = ap.write;
        hsize[d]  = ap.size;
        haddr[d]  = ap.addr;
        hburst[d] = 3'd1;
        hwdata[d] = wd;
    endtask

    // Pipelined master: runs seq on instance d, checking every cycle.
    task automatic run(input int d);
        item_t       idle_it;
        item_t       ap;
        item_t       dp;
        bit          dpv = 0;
        bit          cancel = 0;
        bit          derr;
        bit          mok;
        int          idx = 0;
        int          cnt = 0;
        int          guard = 0;
        logic        rdy;
        logic [31:0] exp;
        idle_it = '{sel: 1'b0, trans: 2'd0, write: 1'b0, size: 3'd0, addr: 32'h0,
                    wdata: 32'h0};
        dp = idle_it;
        while ((idx < seq.size() || dpv) && guard < 5000) begin
            guard++;
            @(posedge clk); #1;
            ap = (cancel || idx >= seq.size()) ? idle_it : seq[idx];
            drive(d, ap, dpv ? dp.wdata : 32'h0);
            @(negedge clk);
            rdy = hready_o[d];
            if (dpv) begin
                derr = is_err(dp);
                if (derr) begin
                    check($sformatf("d%0d c%0d err_rdy", d, guard), {31'b0, rdy}, {31'b0, cnt != 0});
                    check($sformatf("d%0d c%0d err_resp", d, guard), {31'b0, hresp[d]}, 32'd1);
                    check($sformatf("d%0d c%0d err_rdata", d, guard), hrdata[d], 32'h0);
                end else begin
                    check($sformatf("d%0d c%0d ok_rdy", d, guard), {31'b0, rdy},
                          {31'b0, cnt == wst[d]});
                    check($sformatf("d%0d c%0d ok_resp", d, guard), {31'b0, hresp[d]}, 32'd0);
                    if (cnt == wst[d] && !dp.write) begin
                        exp = 32'h0;
                        mok = 1;
                        for (int k = 0; k < nbytes(dp.size); k++) begin
                            if (!mv[d][int'(dp.addr) + k]) mok = 0;
                            exp[8*k +: 8] = mm[d][int'(dp.addr) + k];
                        end
                        if (mok) check($sformatf("d%0d c%0d rdata a=%h", d, guard, dp.addr),
                                       hrdata[d], exp);
                    end
                end
            end else begin
                derr = 0;
                check($sformatf("d%0d c%0d idle_rdy", d, guard), {31'b0, rdy}, 32'd1);
                check($sformatf("d%0d c%0d idle_resp", d, guard), {31'b0, hresp[d]}, 32'd0);
            end
            if (rdy) begin
                if (dpv && !derr && dp.write) begin
                    for (int k = 0; k < nbytes(dp.size); k++) begin
                        mm[d][int'(dp.addr) + k] = dp.wdata[8*k +: 8];
                        mv[d][int'(dp.addr) + k] = 1;
                    end
                end
                if (dpv && !derr && !dp.write) last_rdata = hrdata[d];
                dpv = ap.sel && ap.trans[1];
                dp  = ap;
                cnt = 0;
                if (!cancel && idx < seq.size()) idx++;
                cancel = 0;
            end else begin
                // ERR1 cycle: master cancels by driving IDLE during ERR2.
                if (dpv && derr && cnt == 0) cancel = 1;
                cnt++;
            end
        end
        if (guard >= 5000) check($sformatf("d%0d run_timeout", d), 32'd1, 32'd0);
        seq.delete();
    endtask

    // Start a word transfer on instance 1, reset it during the wait states.
    task automatic rst_mid(input logic wr, input logic [31:0] a, input logic [31:0] wd);
        item_t it;
        it = '{sel: 1'b1, trans: 2'd2, write: wr, size: 3'd2, addr: a, wdata: wd};
        @(posedge clk); #1;
        drive(1, it, 32'h0);
        @(negedge clk);
        check("rst_mid pre_rdy", {31'b0, hready_o[1]}, 32'd1);
        @(posedge clk); #1;
        it.sel = 1'b0; it.trans = 2'd0;
        drive(1, it, wd);
        @(negedge clk);
        check("rst_mid wait_rdy", {31'b0, hready_o[1]}, 32'd0);
        hrst[1] = 1'b1;
        @(posedge clk); #1;
        hrst[1] = 1'b0;
        @(negedge clk);
        check("rst_mid post_rdy", {31'b0, hready_o[1]}, 32'd1);
        check("rst_mid post_resp", {31'b0, hresp[1]}, 32'd0);
        check("rst_mid post_rdata", hrdata[1], 32'h0);
    endtask

    initial begin
        item_t idle_it;
        int    r;
        logic [2:0]  sz;
        logic [31:0] a;
        idle_it = '{sel: 1'b0, trans: 2'd0, write: 1'b0, size: 3'd0, addr: 32'h0,
                    wdata: 32'h0};
        for (int d = 0; d < 2; d++) begin
            hrst[d] = 1'b1;
            drive(d, idle_it, 32'h0);
        end
        repeat (3) @(posedge clk);
        #1;
        hrst[0] = 1'b0;
        hrst[1] = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("reset d%0d rdy", d), {31'b0, hready_o[d]}, 32'd1);
            check($sformatf("reset d%0d resp", d), {31'b0, hresp[d]}, 32'd0);
            check($sformatf("reset d%0d rdata", d), hrdata[d], 32'h0);
        end

        // Fill instance 0 so every random read has a known answer.
        for (int i = 0; i < int'(MEM) / 4; i++) add(1, 2'd3, 1, 3'd2, 32'(4 * i), $urandom);
        run(0);

        add(1, 2'd2, 1, 3'd2, 32'h10, 32'h44332211);
        add(1, 2'd2, 0, 3'd2, 32'h10, 32'h0);
        run(0);
        check("word_rw 0x10", last_rdata, 32'h44332211);

        add(1, 2'd2, 1, 3'd1, 32'h20, 32'h1111);
        add(1, 2'd3, 1, 3'd1, 32'h22, 32'h2222);
        add(1, 2'd1, 1, 3'd1, 32'h24, 32'h0);
        add(1, 2'd3, 1, 3'd1, 32'h24, 32'h3333);
        add(1, 2'd3, 1, 3'd1, 32'h26, 32'h4444);
        add(1, 2'd2, 0, 3'd0, 32'h23, 32'h0);
        run(0);
        check("incr4_half byte 0x23", last_rdata, 32'h00000022);

        add(1, 2'd2, 1, 3'd2, 32'h60, 32'hCAFEF00D);
        add(1, 2'd2, 0, 3'd2, MEM + 1, 32'h0);
        add(1, 2'd2, 1, 3'd2, 32'h61, 32'h0);
        add(1, 2'd2, 0, 3'd2, 32'h60, 32'h0);
        run(0);
        check("err_no_write 0x60", last_rdata, 32'hCAFEF00D);

        add(1, 2'd2, 1, 3'd2, 32'h40, 32'hAABBCCDD);
        add(1, 2'd2, 0, 3'd2, 32'h40, 32'h0);
        run(0);
        check("forward 0x40", last_rdata, 32'hAABBCCDD);

        for (int i = 0; i < 300; i++) begin
            r  = $urandom_range(0, 19);
            sz = (r == 0) ? 3'd3 : 3'(r % 3);
            r  = $urandom_range(0, 14);
            if (r == 0)      a = MEM + $urandom_range(0, 64);
            else if (r == 1) a = $urandom_range(0, MEM - 1);
            else             a = $urandom_range(0, MEM - 1) & ~32'(nbytes(sz) - 1);
            r  = $urandom_range(0, 9);
            add($urandom_range(0, 9) != 0, (r == 0) ? 2'd0 : (r == 1) ? 2'd1 :
                2'($urandom_range(2, 3)), 1'($urandom_range(0, 1)), sz, a, $urandom);
        end
        run(0);

        // Instance 1: two wait states per OKAY data phase.
        add(1, 2'd2, 1, 3'd2, 32'h0, 32'h12345678);
        add(1, 2'd2, 0, 3'd2, 32'h0, 32'h0);
        add(1, 2'd2, 1, 3'd2, 32'h4, 32'h0BADF00D);
        add(1, 2'd2, 0, 3'd2, MEM + 1, 32'h0);
        add(1, 2'd2, 0, 3'd2, 32'h4, 32'h0);
        run(1);
        check("wait2 read 0x4", last_rdata, 32'h0BADF00D);

        rst_mid(1'b0, 32'h0, 32'h0);
        rst_mid(1'b1, 32'h4, 32'hDEADBEEF);
        add(1, 2'd2, 0, 3'd2, 32'h4, 32'h0);
        run(1);
        check("rst_abort keeps 0x4", last_rdata, 32'h0BADF00D);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
